uart_tx_arbiter: RTL and testbench

Shares the single UART_TX byte transmitter between NREQ independent byte sources, for example the data-memory dump engine, a register dumper and debug printers. It arbitrates round-robin per byte and drives the transmitter's SEND/DATA handshake. A per-requester lock keeps a multi-byte message (e.g. 8 hex digits + CR + LF) contiguous on the line. It sits between the requesters and UART_TX, which the arbiter does not instantiate.

---
 rtl/uart_tx_arbiter.sv | 119 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin byte arbiter with per-requester lock in front of UART_TX; optional counter under UART_TX_ARBITER_COUNT_EN
module uart_tx_arbiter #(
  parameter int NREQ = 2
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   lock,
  input  logic [8*NREQ-1:0] data,
  output logic [NREQ-1:0]   gnt,
  output logic [1:0]        owner,
  output logic              busy,
  output logic              uart_send,
  output logic [7:0]        uart_data,
  input  logic              uart_ready,
  output logic [15:0]       tx_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SEND  = 2'd1;
  localparam logic [1:0] GUARD = 2'd2;
  localparam logic [1:0] WAIT  = 2'd3;
  localparam logic [1:0] LAST  = 2'(NREQ - 1);

  logic [1:0] state;
  logic [7:0] hold;
  logic       own_lock;
  logic       own_req;
  logic       found;
  logic [1:0] win;
  logic [1:0] cand;
  logic [7:0] win_data;

  // Pick the next requester: the locked owner exclusively, otherwise round-robin after owner.
  always_comb begin
    own_lock = 1'b0;
    own_req  = 1'b0;
    found    = 1'b0;
    win      = owner;
    cand     = owner;
    win_data = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == 2'(i)) begin
        own_lock = lock[i];
        own_req  = req[i];
      end
    end
    if (own_lock) begin
      found = own_req;
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        cand = 2'((int'(owner) + k) % NREQ);
        for (int i = 0; i < NREQ; i++) begin
          if (!found && cand == 2'(i) && req[i]) begin
            found = 1'b1;
            win   = cand;
          end
        end
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (win == 2'(i)) begin
        win_data = data[8*i +: 8];
      end
    end
  end

  // Byte handshake sequencer: IDLE -> SEND -> GUARD -> WAIT -> IDLE.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= LAST;
      hold  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (uart_ready && found) begin
            hold  <= win_data;
            owner <= win;
            state <= SEND;
          end
        end
        SEND:    state <= GUARD;
        GUARD:   state <= WAIT;
        default: if (uart_ready) state <= IDLE;
      endcase
    end
  end

  // Grant pulse goes to the owner only during SEND.
  always_comb begin
    gnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt[i] = (state == SEND) && (owner == 2'(i));
    end
  end

  assign busy      = (state != IDLE);
  assign uart_send = (state == SEND);
  assign uart_data = (state == IDLE) ? 8'h00 : hold;

`ifdef UART_TX_ARBITER_COUNT_EN
  logic [15:0] count;

  // Count every byte handed to the transmitter; wraps naturally at 16 bits.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      count <= 16'h0000;
    end else if (state == SEND) begin
      count <= count + 16'h0001;
    end
  end

  assign tx_count = count;
`else
  assign tx_count = 16'h0000;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed vector bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  lock = '0;
  logic [15:0] data = '0;
  logic [1:0]  gnt;
  logic [1:0]  owner;
  logic        busy;
  logic        uart_send;
  logic [7:0]  uart_data;
  logic        uart_ready = 1'b1;
  logic [15:0] tx_count;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [1:0] lock;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       rdy;
    logic       e_send;
    logic [7:0] e_data;
    logic [1:0] e_gnt;
    logic [1:0] e_owner;
    logic       e_busy;
  } vec_t;

  vec_t tbl[$];

  uart_tx_arbiter #(.NREQ(2)) dut (
    .CLK(CLK), .rst(rst), .req(req), .lock(lock), .data(data),
    .gnt(gnt), .owner(owner), .busy(busy), .uart_send(uart_send),
    .uart_data(uart_data), .uart_ready(uart_ready), .tx_count(tx_count)
  );

  always #5 CLK = ~CLK;

  function automatic vec_t mk(logic r, logic [1:0] rq, logic [1:0] lk, logic [7:0] a, logic [7:0] b,
                              logic rd, logic s, logic [7:0] d, logic [1:0] g, logic [1:0] o, logic bz);
    vec_t v;
    v.rst = r; v.req = rq; v.lock = lk; v.d0 = a; v.d1 = b; v.rdy = rd;
    v.e_send = s; v.e_data = d; v.e_gnt = g; v.e_owner = o; v.e_busy = bz;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Test 1: single byte from requester 0, full handshake back to IDLE.
    tbl.push_back(mk(1, 2'b00, 2'b00, 8'h00, 8'h00, 1, 0, 8'h00, 2'b00, 2'd1, 0));
    tbl.push_back(mk(0, 2'b01, 2'b00, 8'h41, 8'h00, 1, 1, 8'h41, 2'b01, 2'd0, 1));
    tbl.push_back(mk(0, 2'b00, 2'b00, 8'h41, 8'h00, 1, 0, 8'h41, 2'b00, 2'd0, 1));
    tbl.push_back(mk(0, 2'b00, 2'b00, 8'h41, 8'h00, 0, 0, 8'h41, 2'b00, 2'd0, 1));
    tbl.push_back(mk(0, 2'b00, 2'b00, 8'h41, 8'h00, 0, 0, 8'h41, 2'b00, 2'd0, 1));
    tbl.push_back(mk(0, 2'b00, 2'b00, 8'h41, 8'h00, 1, 0, 8'h00, 2'b00, 2'd0, 0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 8'h41, 8'h00, 1, 0, 8'h00, 2'b00, 2'd0, 0));
    // Test 2: both requesting continuously, unlocked -> alternate 0,1,0,1.
    tbl.push_back(mk(1, 2'b00, 2'b00, 8'h30, 8'h31, 1, 0, 8'h00, 2'b00, 2'd1, 0));
    for (int n = 0; n < 4; n++) begin
      logic [7:0] b;
      logic [1:0] g;
      logic [1:0] o;
      b = (n % 2 == 0) ? 8'h30 : 8'h31;
      g = (n % 2 == 0) ? 2'b01 : 2'b10;
      o = (n % 2 == 0) ? 2'd0 : 2'd1;
      tbl.push_back(mk(0, 2'b11, 2'b00, 8'h30, 8'h31, 1, 1, b, g, o, 1));
      if (n < 3) begin
        tbl.push_back(mk(0, 2'b11, 2'b00, 8'h30, 8'h31, 1, 0, b, 2'b00, o, 1));
        tbl.push_back(mk(0, 2'b11, 2'b00, 8'h30, 8'h31, 1, 0, b, 2'b00, o, 1));
        tbl.push_back(mk(0, 2'b11, 2'b00, 8'h30, 8'h31, 1, 0, 8'h00, 2'b00, o, 0));
      end
    end
    // Test 3: locked message 44 0D 0A from requester 0, then pending 55 from requester 1.
    tbl.push_back(mk(1, 2'b00, 2'b00, 8'h00, 8'h00, 1, 0, 8'h00, 2'b00, 2'd1, 0));
    tbl.push_back(mk(0, 2'b11, 2'b01, 8'h44, 8'h55, 1, 1, 8'h44, 2'b01, 2'd0, 1));
    tbl.push_back(mk(0, 2'b11, 2'b01, 8'h0D, 8'h55, 1, 0, 8'h44, 2'b00, 2'd0, 1));
    tbl.push_back(mk(0, 2'b11, 2'b01, 8'h0D, 8'h55, 1, 0, 8'h44, 2'b00, 2'd0, 1));
    tbl.push_back(mk(0, 2'b11, 2'b01, 8'h0D, 8'h55, 1, 0, 8'h00, 2'b00, 2'd0, 0));
    tbl.push_back(mk(0, 2'b11, 2'b01, 8'h0D, 8'h55, 1, 1, 8'h0D, 2'b01, 2'd0, 1));
    tbl.push_back(mk(0, 2'b11, 2'b01, 8'h0A, 8'h55, 1, 0, 8'h0D, 2'b00, 2'd0, 1));
    tbl.push_back(mk(0, 2'b11, 2'b01, 8'h0A, 8'h55, 1, 0, 8'h0D, 2'b00, 2'd0, 1));
    tbl.push_back(mk(0, 2'b11, 2'b01, 8'h0A, 8'h55, 1, 0, 8'h00, 2'b00, 2'd0, 0));
    tbl.push_back(mk(0, 2'b11, 2'b01, 8'h0A, 8'h55, 1, 1, 8'h0A, 2'b01, 2'd0, 1));
    tbl.push_back(mk(0, 2'b10, 2'b00, 8'h0A, 8'h55, 1, 0, 8'h0A, 2'b00, 2'd0, 1));
    tbl.push_back(mk(0, 2'b10, 2'b00, 8'h0A, 8'h55, 1, 0, 8'h0A, 2'b00, 2'd0, 1));
    tbl.push_back(mk(0, 2'b10, 2'b00, 8'h0A, 8'h55, 1, 0, 8'h00, 2'b00, 2'd0, 0));
    tbl.push_back(mk(0, 2'b10, 2'b00, 8'h0A, 8'h55, 1, 1, 8'h55, 2'b10, 2'd1, 1));
    // Lock held with owner's req low stalls requester 1 until lock drops.
    tbl.push_back(mk(1, 2'b00, 2'b00, 8'h00, 8'h00, 1, 0, 8'h00, 2'b00, 2'd1, 0));
    tbl.push_back(mk(0, 2'b01, 2'b01, 8'h44, 8'h55, 1, 1, 8'h44, 2'b01, 2'd0, 1));
    tbl.push_back(mk(0, 2'b10, 2'b01, 8'h44, 8'h55, 1, 0, 8'h44, 2'b00, 2'd0, 1));
    tbl.push_back(mk(0, 2'b10, 2'b01, 8'h44, 8'h55, 1, 0, 8'h44, 2'b00, 2'd0, 1));
    tbl.push_back(mk(0, 2'b10, 2'b01, 8'h44, 8'h55, 1, 0, 8'h00, 2'b00, 2'd0, 0));
    tbl.push_back(mk(0, 2'b10, 2'b01, 8'h44, 8'h55, 1, 0, 8'h00, 2'b00, 2'd0, 0));
    tbl.push_back(mk(0, 2'b10, 2'b01, 8'h44, 8'h55, 1, 0, 8'h00, 2'b00, 2'd0, 0));
    tbl.push_back(mk(0, 2'b10, 2'b00, 8'h44, 8'h55, 1, 1, 8'h55, 2'b10, 2'd1, 1));

    tick();
    tick();
    for (int i = 0; i < tbl.size(); i++) begin
      rst        = tbl[i].rst;
      req        = tbl[i].req;
      lock       = tbl[i].lock;
      data       = {tbl[i].d1, tbl[i].d0};
      uart_ready = tbl[i].rdy;
      tick();
      if (tbl[i].rst) exp_cnt = 0;
      chk($sformatf("row%0d send", i), 32'(uart_send), 32'(tbl[i].e_send));
      chk($sformatf("row%0d data", i), 32'(uart_data), 32'(tbl[i].e_data));
      chk($sformatf("row%0d gnt", i), 32'(gnt), 32'(tbl[i].e_gnt));
      chk($sformatf("row%0d owner", i), 32'(owner), 32'(tbl[i].e_owner));
      chk($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
`ifdef UART_TX_ARBITER_COUNT_EN
      chk($sformatf("row%0d tx_count", i), 32'(tx_count), exp_cnt);
`else
      chk($sformatf("row%0d tx_count", i), 32'(tx_count), 32'd0);
`endif
      if (tbl[i].e_send) exp_cnt++;
    end
    rst = 1'b0;

    // Test 4: transmitter not ready holds off the request for 20 cycles.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 2'b01;
    lock = 2'b00;
    data = {8'h00, 8'h5A};
    uart_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk($sformatf("stall%0d send", c), 32'(uart_send), 32'd0);
      chk($sformatf("stall%0d gnt", c), 32'(gnt), 32'd0);
    end
    uart_ready = 1'b1;
    tick();
    chk("ready send", 32'(uart_send), 32'd1);
    chk("ready gnt", 32'(gnt), 32'b01);
    chk("ready data", 32'(uart_data), 32'h5A);

    // Test 5: asynchronous reset in WAIT abandons the byte.
    req = 2'b00;
    tick();
    uart_ready = 1'b0;
    tick();
    tick();
    chk("wait busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst busy", 32'(busy), 32'd0);
    chk("arst data", 32'(uart_data), 32'h00);
    chk("arst gnt", 32'(gnt), 32'd0);
    chk("arst send", 32'(uart_send), 32'd0);
    chk("arst owner", 32'(owner), 32'd1);
    chk("arst tx_count", 32'(tx_count), 32'd0);
    req = 2'b11;
    data = {8'h62, 8'h61};
    uart_ready = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("post rst send", 32'(uart_send), 32'd1);
    chk("post rst gnt", 32'(gnt), 32'b01);
    chk("post rst owner", 32'(owner), 32'd0);
    chk("post rst data", 32'(uart_data), 32'h61);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
